// File: rtl/interrupt_controller.sv
// Edge-latching interrupt controller: synchronizes irq lines, latches pending requests,
// masks them and presents one stable priority-encoded code to the control FSM.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | no code presented (code_q=0); code_q tracks selection
// ST_PRESENTED | code_q!=0 held for the FSM, waiting for the acknowledge
// ST_SERVICE   | acknowledged request in service (busy); code_q held
module interrupt_controller #(
  parameter  int INTERRUPT_WIDTH = 4,
  localparam int SOURCES = 2**INTERRUPT_WIDTH - 1,
  parameter  logic [SOURCES-1:0] MASK_RESET = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SOURCES-1:0]         irq,
  input  logic                       mask_we,
  input  logic [SOURCES-1:0]         mask_wdata,
  input  logic                       processing_interrupt,
  output logic [INTERRUPT_WIDTH-1:0] interrupt,
  output logic [SOURCES-1:0]         pending,
  output logic                       busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESENTED = 2'd1,
    ST_SERVICE   = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [INTERRUPT_WIDTH-1:0] code_q, code_d;
  logic [SOURCES-1:0]         s1, s2, s3;
  logic [SOURCES-1:0]         pending_q;
  logic [SOURCES-1:0]         mask_q;
  logic [SOURCES-1:0]         rise;
  logic [SOURCES-1:0]         clr;
  logic [SOURCES-1:0]         cand;
  logic [INTERRUPT_WIDTH-1:0] sel;
  logic                       ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 resets low, so a line already high at reset release yields one edge
  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= MASK_RESET;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  assign cand = pending_q & ~mask_q;

  always_comb begin
    sel = '0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (cand[i]) sel = INTERRUPT_WIDTH'(i + 1);
    end
  end

  assign ack = (state_q == ST_PRESENTED) && processing_interrupt;

  always_comb begin
    clr = '0;
    for (int i = 0; i < SOURCES; i++) begin
      clr[i] = ack && (code_q == INTERRUPT_WIDTH'(i + 1));
    end
  end

  // OR-ing the new edges after the clear lets a coincident edge win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        code_d  = sel;
        state_d = (sel != '0) ? ST_PRESENTED : ST_IDLE;
      end
      ST_PRESENTED: begin
        if (processing_interrupt) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (!processing_interrupt) begin
          code_d  = sel;
          state_d = (sel != '0) ? ST_PRESENTED : ST_IDLE;
        end
      end
      default: begin
        code_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == ST_SERVICE);
  assign interrupt = (busy && !processing_interrupt) ? '0 : code_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; expected values are hand-derived
// from the edge-latency and handshake rules of the block.
module tb_interrupt_controller;

  localparam int W = 4;
  localparam int S = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [S-1:0] irq;
  logic         mask_we;
  logic [S-1:0] mask_wdata;
  logic         processing_interrupt;
  logic [W-1:0] interrupt;
  logic [S-1:0] pending;
  logic         busy;

  int checks = 0;
  int errors = 0;

  interrupt_controller dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .irq                  (irq),
    .mask_we              (mask_we),
    .mask_wdata           (mask_wdata),
    .processing_interrupt (processing_interrupt),
    .interrupt            (interrupt),
    .pending              (pending),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    irq = '0;
    mask_we = 1'b0;
    mask_wdata = '0;
    processing_interrupt = 1'b0;
    #1;
    chk("reset_interrupt", 32'(interrupt), 32'd0);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // single pulse on irq[2]: pending after 3 edges, code 3 one edge later
    irq = 15'h0004;
    tick(2);
    irq = '0;
    chk("p2_before_e2", 32'(pending), 32'h0);
    tick();
    chk("p2_pending", 32'(pending), 32'h0004);
    chk("p2_not_yet", 32'(interrupt), 32'd0);
    tick();
    chk("p2_code", 32'(interrupt), 32'd3);
    processing_interrupt = 1'b1;
    tick();
    chk("p2_ack_busy", 32'(busy), 32'd1);
    chk("p2_ack_pending", 32'(pending), 32'h0);
    chk("p2_ack_hold", 32'(interrupt), 32'd3);
    processing_interrupt = 1'b0;
    #1;
    chk("p2_ret_blank", 32'(interrupt), 32'd0);
    tick();
    chk("p2_ret_idle", 32'(interrupt), 32'd0);
    chk("p2_ret_busy", 32'(busy), 32'd0);
    tick(3);

    // irq[4] and irq[1] together: lowest index wins, then code 5 after return
    irq = 15'h0012;
    tick(4);
    chk("dual_code", 32'(interrupt), 32'd2);
    chk("dual_pending", 32'(pending), 32'h0012);
    processing_interrupt = 1'b1;
    tick();
    chk("dual_ack_pending", 32'(pending), 32'h0010);
    chk("dual_ack_busy", 32'(busy), 32'd1);
    chk("dual_ack_code", 32'(interrupt), 32'd2);
    tick(2);
    chk("dual_service_hold", 32'(interrupt), 32'd2);
    processing_interrupt = 1'b0;
    #1;
    chk("dual_ret_blank", 32'(interrupt), 32'd0);
    tick();
    chk("dual_next_code", 32'(interrupt), 32'd5);
    chk("dual_next_busy", 32'(busy), 32'd0);
    processing_interrupt = 1'b1;
    tick();
    chk("dual5_ack_pending", 32'(pending), 32'h0);
    processing_interrupt = 1'b0;
    tick();
    chk("dual5_ret_code", 32'(interrupt), 32'd0);
    irq = '0;
    tick(4);

    // ack while nothing is presented is ignored
    processing_interrupt = 1'b1;
    tick(2);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_code", 32'(interrupt), 32'd0);
    processing_interrupt = 1'b0;
    tick();

    // no preemption: code 6 stays while higher-priority irq[0] arrives
    irq = 15'h0020;
    tick(4);
    chk("nopre_code6", 32'(interrupt), 32'd6);
    irq = 15'h0021;
    tick(4);
    chk("nopre_pending", 32'(pending), 32'h0021);
    chk("nopre_hold6", 32'(interrupt), 32'd6);
    processing_interrupt = 1'b1;
    tick();
    chk("nopre_ack_pending", 32'(pending), 32'h0001);
    chk("nopre_ack_code", 32'(interrupt), 32'd6);
    processing_interrupt = 1'b0;
    #1;
    chk("nopre_ret_blank", 32'(interrupt), 32'd0);
    tick();
    chk("nopre_next_code1", 32'(interrupt), 32'd1);
    processing_interrupt = 1'b1;
    tick();
    processing_interrupt = 1'b0;
    tick();
    chk("nopre_done", 32'(interrupt), 32'd0);
    irq = '0;
    tick(4);

    // masked line still latches pending but is not selected
    mask_we = 1'b1;
    mask_wdata = 15'h0008;
    tick();
    mask_we = 1'b0;
    irq = 15'h0008;
    tick(3);
    chk("mask_pending", 32'(pending), 32'h0008);
    tick(2);
    chk("mask_blocked", 32'(interrupt), 32'd0);
    mask_we = 1'b1;
    mask_wdata = '0;
    tick();
    mask_we = 1'b0;
    chk("unmask_first_edge", 32'(interrupt), 32'd0);
    tick();
    chk("unmask_code4", 32'(interrupt), 32'd4);
    processing_interrupt = 1'b1;
    tick();
    processing_interrupt = 1'b0;
    tick();
    chk("unmask_done", 32'(interrupt), 32'd0);
    irq = '0;
    tick(4);

    // re-trigger on irq[1] whose edge coincides with the acknowledge clear
    irq = 15'h0002;
    tick(4);
    chk("retrig_code2", 32'(interrupt), 32'd2);
    irq = '0;
    tick(3);
    irq = 15'h0002;
    tick(2);
    processing_interrupt = 1'b1;
    tick();
    chk("retrig_set_wins", 32'(pending), 32'h0002);
    chk("retrig_busy", 32'(busy), 32'd1);
    chk("retrig_hold", 32'(interrupt), 32'd2);
    processing_interrupt = 1'b0;
    tick();
    chk("retrig_again2", 32'(interrupt), 32'd2);
    processing_interrupt = 1'b1;
    tick();
    chk("retrig_clear", 32'(pending), 32'h0);
    processing_interrupt = 1'b0;
    tick();
    irq = '0;
    tick(4);

    // async reset while in service with pending 0x3
    irq = 15'h0004;
    tick(4);
    processing_interrupt = 1'b1;
    tick();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    irq = 15'h0007;
    tick(3);
    chk("rst_pre_pending", 32'(pending), 32'h0003);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_pending", 32'(pending), 32'h0);
    chk("rst_mid_interrupt", 32'(interrupt), 32'd0);
    processing_interrupt = 1'b0;
    irq = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
